// File: rtl/dp_sequencer.sv
// Micro-command sequencer for the RA/RB/RZ adder datapath: accepts LDA/MOVAB/ADD/ACC
// commands over a ready/start handshake and steps the register strobes until done.
module dp_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              abort,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] RegisterAImmediate,
    output logic              RAin,
    output logic              RBin,
    output logic              RZin,
    output logic              RAout,
    output logic              RBout,
    output logic              RZout
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MOVE,
        ADD,
        ACC_Z,
        ACC_B,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state              <= IDLE;
            cnt                <= '0;
            RegisterAImmediate <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (ready && start) begin
                RegisterAImmediate <= imm_in;
            end
        end
    end

    // Strobes depend only on the state register; start/abort only steer the next state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        done      = 1'b0;
        RAin      = 1'b0;
        RBin      = 1'b0;
        RZin      = 1'b0;
        RAout     = 1'b0;
        RBout     = 1'b0;
        RZout     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    case (op)
                        2'b00: state_nxt = LOAD;
                        2'b01: state_nxt = MOVE;
                        2'b10: state_nxt = ADD;
                        default: begin
                            cnt_nxt   = cnt_in;
                            state_nxt = (cnt_in != '0) ? ACC_Z : DONE;
                        end
                    endcase
                end
            end
            LOAD: begin
                RAin      = 1'b1;
                state_nxt = abort ? IDLE : DONE;
            end
            MOVE: begin
                RAout     = 1'b1;
                RBin      = 1'b1;
                state_nxt = abort ? IDLE : DONE;
            end
            ADD: begin
                RBout     = 1'b1;
                RZin      = 1'b1;
                state_nxt = abort ? IDLE : DONE;
            end
            ACC_Z: begin
                RBout     = 1'b1;
                RZin      = 1'b1;
                state_nxt = abort ? IDLE : ACC_B;
            end
            ACC_B: begin
                RZout = 1'b1;
                RBin  = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    // The count is at least 1 here; the guard keeps it from ever wrapping.
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                    state_nxt = (cnt > CNT_W'(1)) ? ACC_Z : DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer with a behavioural RA/RB/RZ datapath driven by its strobes.
module tb_dp_sequencer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    // {RAin,RBin,RZin,RAout,RBout,RZout}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LOAD = 6'b100000;
    localparam logic [5:0] S_ACCZ = 6'b001010;
    localparam logic [5:0] S_ACCB = 6'b010001;

    logic              clock = 1'b0;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        op = 2'b00;
    logic [DATA_W-1:0] imm_in = '0;
    logic [CNT_W-1:0]  cnt_in = '0;
    logic              abort = 1'b0;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] RegisterAImmediate;
    logic              RAin, RBin, RZin, RAout, RBout, RZout;

    logic [DATA_W-1:0] ra = '0;
    logic [DATA_W-1:0] rb = '0;
    logic [DATA_W-1:0] rz = '0;
    logic [DATA_W-1:0] bus;
    logic [5:0]        strobes;

    int vectors = 0;
    int miscompares = 0;
    int done_count = 0;

    dp_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .clear(clear),
        .start(start),
        .op(op),
        .imm_in(imm_in),
        .cnt_in(cnt_in),
        .abort(abort),
        .ready(ready),
        .done(done),
        .RegisterAImmediate(RegisterAImmediate),
        .RAin(RAin),
        .RBin(RBin),
        .RZin(RZin),
        .RAout(RAout),
        .RBout(RBout),
        .RZout(RZout)
    );

    always #5 clock = ~clock;

    assign strobes = {RAin, RBin, RZin, RAout, RBout, RZout};
    assign bus = RAout ? ra : (RBout ? rb : (RZout ? rz : '0));

    // Reference datapath: RA loads the immediate, RB loads the bus, RZ loads RA + bus.
    always @(posedge clock) begin
        if (RAin) ra <= RegisterAImmediate;
        if (RBin) rb <= bus;
        if (RZin) rz <= ra + bus;
    end

    // Advance one cycle, sample #1 after the edge, and check the strobe invariants.
    task automatic step();
        @(posedge clock);
        #1;
        if (done) done_count++;
        vectors++;
        if ($countones({RAout, RBout, RZout}) > 1) begin
            miscompares++;
            $display("[TB] FAIL bus_onehot t=%0t got %b required at most one high", $time, {RAout, RBout, RZout});
        end
        vectors++;
        if ($countones({RAin, RBin, RZin}) > 1) begin
            miscompares++;
            $display("[TB] FAIL load_onehot t=%0t got %b required at most one high", $time, {RAin, RBin, RZin});
        end
    endtask

    // Present a command for one accept edge; returns sampled in cycle 1 after accept.
    task automatic issue(input logic [1:0] o, input logic [DATA_W-1:0] imm, input logic [CNT_W-1:0] c);
        start  = 1'b1;
        op     = o;
        imm_in = imm;
        cnt_in = c;
        step();
        start = 1'b0;
    endtask

    // Issue a command and wait (bounded) for done; latency -1 means it never came.
    task automatic run_cmd(input logic [1:0] o, input logic [DATA_W-1:0] imm,
                           input logic [CNT_W-1:0] c, output int latency);
        latency = -1;
        issue(o, imm, c);
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                latency = i;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #12;
        vectors++;
        if ({ready, done, strobes, RegisterAImmediate} !== {1'b1, 1'b0, S_NONE, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL reset_state got %b required %b", {ready, done, strobes, RegisterAImmediate},
                     {1'b1, 1'b0, S_NONE, 8'h00});
        end
        @(negedge clock);
        clear = 1'b1;
        step();
    endtask

    task automatic test_lda();
        issue(OP_LDA, 8'h25, 4'd0);
        vectors++;
        if ({strobes, done, ready, RegisterAImmediate} !== {S_LOAD, 1'b0, 1'b0, 8'h25}) begin
            miscompares++;
            $display("[TB] FAIL lda_cycle1 got %b required %b", {strobes, done, ready, RegisterAImmediate},
                     {S_LOAD, 1'b0, 1'b0, 8'h25});
        end
        step();
        vectors++;
        if ({strobes, done} !== {S_NONE, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL lda_cycle2 got %b required %b", {strobes, done}, {S_NONE, 1'b1});
        end
        step();
        vectors++;
        if ({ready, done, ra} !== {1'b1, 1'b0, 8'h25}) begin
            miscompares++;
            $display("[TB] FAIL lda_result got %b required %b", {ready, done, ra}, {1'b1, 1'b0, 8'h25});
        end
    endtask

    task automatic test_move_add();
        int lat;
        int d0;
        d0 = done_count;
        run_cmd(OP_MOV, 8'h25, 4'd0, lat);
        vectors++;
        if (lat != 2 || rb !== 8'h25 || ready !== 1'b1 || done_count != d0 + 1) begin
            miscompares++;
            $display("[TB] FAIL movab got lat=%0d rb=%h ready=%b dones=%0d required lat=2 rb=25 ready=1 dones=1",
                     lat, rb, ready, done_count - d0);
        end
        run_cmd(OP_LDA, 8'h10, 4'd0, lat);
        d0 = done_count;
        run_cmd(OP_ADD, 8'h10, 4'd0, lat);
        vectors++;
        if (lat != 2 || rz !== 8'h35 || ready !== 1'b1 || done_count != d0 + 1) begin
            miscompares++;
            $display("[TB] FAIL add got lat=%0d rz=%h ready=%b dones=%0d required lat=2 rz=35 ready=1 dones=1",
                     lat, rz, ready, done_count - d0);
        end
    endtask

    task automatic test_acc();
        int lat;
        int bad;
        run_cmd(OP_LDA, 8'h05, 4'd0, lat);
        run_cmd(OP_MOV, 8'h05, 4'd0, lat);
        run_cmd(OP_LDA, 8'h03, 4'd0, lat);
        issue(OP_ACC, 8'h03, 4'd3);
        bad = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            vectors++;
            if (strobes !== ((cyc % 2 == 1) ? S_ACCZ : S_ACCB) || done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL acc3_trace cycle %0d got %b/%b required %b/0", cyc, strobes, done,
                         (cyc % 2 == 1) ? S_ACCZ : S_ACCB);
            end
            step();
        end
        vectors++;
        if ({strobes, done} !== {S_NONE, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL acc3_done_cycle7 got %b required %b", {strobes, done}, {S_NONE, 1'b1});
        end
        step();
        vectors++;
        if (rb !== 8'h0E || rz !== 8'h0E || ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL acc3_result got rb=%h rz=%h ready=%b required rb=0e rz=0e ready=1", rb, rz, ready);
        end
        run_cmd(OP_LDA, 8'h20, 4'd0, lat);
        run_cmd(OP_MOV, 8'h20, 4'd0, lat);
        run_cmd(OP_LDA, 8'hF0, 4'd0, lat);
        run_cmd(OP_ACC, 8'hF0, 4'd2, lat);
        vectors++;
        if (lat != 5 || rb !== 8'h00 || rz !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL acc_wrap got lat=%0d rb=%h rz=%h required lat=5 rb=00 rz=00", lat, rb, rz);
        end
        run_cmd(OP_ACC, 8'hF0, 4'd15, lat);
        vectors++;
        if (lat != 31) begin
            miscompares++;
            $display("[TB] FAIL acc15_latency got %0d required 31", lat);
        end
    endtask

    task automatic test_acc_zero();
        issue(OP_ACC, 8'h11, 4'd0);
        vectors++;
        if ({strobes, done, RegisterAImmediate} !== {S_NONE, 1'b1, 8'h11}) begin
            miscompares++;
            $display("[TB] FAIL acc0 got %b required %b", {strobes, done, RegisterAImmediate}, {S_NONE, 1'b1, 8'h11});
        end
        step();
        vectors++;
        if ({ready, done} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL acc0_idle got %b required 10", {ready, done});
        end
    endtask

    task automatic test_busy_start();
        issue(OP_ACC, 8'h5A, 4'd2);
        start  = 1'b1;
        op     = OP_LDA;
        imm_in = 8'h77;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            vectors++;
            if (strobes !== ((cyc % 2 == 1) ? S_ACCZ : S_ACCB) || RegisterAImmediate !== 8'h5A) begin
                miscompares++;
                $display("[TB] FAIL busy_start cycle %0d got %b imm=%h required %b imm=5a", cyc, strobes,
                         RegisterAImmediate, (cyc % 2 == 1) ? S_ACCZ : S_ACCB);
            end
            step();
        end
        start = 1'b0;
        vectors++;
        if ({done, RegisterAImmediate} !== {1'b1, 8'h5A}) begin
            miscompares++;
            $display("[TB] FAIL busy_start_done got %b required %b", {done, RegisterAImmediate}, {1'b1, 8'h5A});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({ready, done, strobes} !== {1'b1, 1'b0, S_NONE}) begin
            miscompares++;
            $display("[TB] FAIL abort_in_done got %b required %b", {ready, done, strobes}, {1'b1, 1'b0, S_NONE});
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_count;
        issue(OP_ACC, 8'h01, 4'd4);
        step();
        step();
        vectors++;
        if (strobes !== S_ACCZ) begin
            miscompares++;
            $display("[TB] FAIL abort_setup got %b required %b", strobes, S_ACCZ);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({ready, done, strobes} !== {1'b1, 1'b0, S_NONE}) begin
            miscompares++;
            $display("[TB] FAIL abort_idle got %b required %b", {ready, done, strobes}, {1'b1, 1'b0, S_NONE});
        end
        for (int i = 0; i < 6; i++) step();
        vectors++;
        if (done_count != d0 || ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done got dones=%0d ready=%b required dones=0 ready=1", done_count - d0, ready);
        end
    endtask

    task automatic test_start_abort_same();
        abort = 1'b1;
        issue(OP_LDA, 8'hC3, 4'd0);
        abort = 1'b0;
        vectors++;
        if ({strobes, RegisterAImmediate} !== {S_LOAD, 8'hC3}) begin
            miscompares++;
            $display("[TB] FAIL start_abort_same got %b required %b", {strobes, RegisterAImmediate}, {S_LOAD, 8'hC3});
        end
        step();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_abort_done got %b required 1", done);
        end
        step();
    endtask

    task automatic test_clear_mid_acc();
        int d0;
        issue(OP_ACC, 8'h42, 4'd5);
        step();
        d0 = done_count;
        #2;
        clear = 1'b0;
        #1;
        vectors++;
        if ({ready, done, strobes, RegisterAImmediate} !== {1'b1, 1'b0, S_NONE, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL clear_mid_acc got %b required %b", {ready, done, strobes, RegisterAImmediate},
                     {1'b1, 1'b0, S_NONE, 8'h00});
        end
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 12; i++) step();
        vectors++;
        if (done_count != d0 || ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clear_no_done got dones=%0d ready=%b required dones=0 ready=1", done_count - d0, ready);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_move_add();
        test_acc();
        test_acc_zero();
        test_busy_start();
        test_abort();
        test_start_abort_same();
        test_clear_mid_acc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
